mio_copy_engine: RTL and testbench

//  Bus initiator (DMA-style copy engine) on the MIO bus; the decoder sits on the responder side.

---
 rtl/mio_copy_engine_if.sv | 26 ++
 rtl/mio_copy_engine.sv | 185 ++++++++++++++++++
 tb/tb_mio_copy_engine.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/mio_copy_engine_if.sv
// MIO bus connection between a bus initiator and the responder side
// (arbiter/decoder).
//   bus_req      initiator -> arbiter   request bus ownership
//   bus_gnt      arbiter -> initiator   ownership granted
//   bus_addr     initiator -> decoder   word/byte address
//   bus_mem_w    initiator -> decoder   write strobe
//   bus_data_out initiator -> decoder   write data
//   bus_data_in  decoder -> initiator   read data (one cycle after address)
interface mio_copy_engine_if;
  logic        bus_req;
  logic        bus_gnt;
  logic [31:0] bus_addr;
  logic        bus_mem_w;
  logic [31:0] bus_data_out;
  logic [31:0] bus_data_in;

  modport master (
    output bus_req, bus_addr, bus_mem_w, bus_data_out,
    input  bus_gnt, bus_data_in
  );

  modport slave (
    input  bus_req, bus_addr, bus_mem_w, bus_data_out,
    output bus_gnt, bus_data_in
  );
endinterface

// File: rtl/mio_copy_engine.sv
// mio_copy_engine: DMA-style copy engine acting as a MIO bus initiator.
// Copies len words from src_addr to dst_addr using ordinary bus cycles, so
// any decoded region can be source or destination (typical use: RAM->VRAM).
// Pointers step by VRAM_STEP inside VRAM_REGION (word-indexed) and by
// RAM_STEP elsewhere (byte-addressed).
//
// Optional feature macro: MIO_COPY_FILL_EN
//   When defined, a start with src_addr[31:28]==4'hF selects fill mode: the
//   read phase is skipped and fill_value is written, one word per cycle.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             1-cycle start pulse (ignored unless idle)
//   src_addr/dst_addr start addresses
//   len               word count (0 completes at once with no bus traffic)
//   fill_value        fill word (fill mode only)
//   bus               MIO initiator port (master modport)
//   busy              transfer in progress (REQ..WR)
//   done              1-cycle completion pulse
//   err               1-cycle pulse on a start rejected for misalignment
//   words_left        remaining word count
module mio_copy_engine #(
  parameter int unsigned LEN_W       = 12,
  parameter logic [3:0]  VRAM_REGION = 4'hC,
  parameter int unsigned RAM_STEP    = 4,
  parameter int unsigned VRAM_STEP   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  input  logic [31:0]      fill_value,
  mio_copy_engine_if.master bus,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [LEN_W-1:0] words_left
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_RD, S_RDW, S_WR, S_DONE
  } state_t;

  state_t           state;
  logic [31:0]      src_q, dst_q, data_q;
  logic [LEN_W-1:0] cnt;
  logic             fill_q;

  function automatic logic [31:0] next_ptr(input logic [31:0] p);
    return p + ((p[31:28] == VRAM_REGION) ? 32'(VRAM_STEP) : 32'(RAM_STEP));
  endfunction

  // Start qualification
  logic fill_sel, src_misalign, dst_misalign, err_cond;

`ifdef MIO_COPY_FILL_EN
  assign fill_sel = (src_addr[31:28] == 4'hF);
`else
  assign fill_sel = 1'b0;
`endif

  assign src_misalign = (src_addr[31:28] != VRAM_REGION) && (src_addr[1:0] != 2'b00);
  assign dst_misalign = (dst_addr[31:28] != VRAM_REGION) && (dst_addr[1:0] != 2'b00);
  // In fill mode the source is never dereferenced, so its alignment is moot.
  assign err_cond     = (src_misalign && !fill_sel) || dst_misalign;

  // Pointer/count values committed at the end of a WR cycle
  logic [31:0]      src_nx, dst_nx;
  logic [LEN_W-1:0] cnt_nx;

  assign src_nx = fill_q ? src_q : next_ptr(src_q);
  assign dst_nx = next_ptr(dst_q);
  assign cnt_nx = cnt - LEN_W'(1);

  assign busy       = (state == S_REQ) || (state == S_RD) ||
                      (state == S_RDW) || (state == S_WR);
  assign words_left = cnt;

  // Single FSM; every bus output is registered for the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      src_q            <= '0;
      dst_q            <= '0;
      data_q           <= '0;
      cnt              <= '0;
      fill_q           <= 1'b0;
      done             <= 1'b0;
      err              <= 1'b0;
      bus.bus_req      <= 1'b0;
      bus.bus_addr     <= '0;
      bus.bus_mem_w    <= 1'b0;
      bus.bus_data_out <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            if (err_cond) begin
              err <= 1'b1;
            end else if (len == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state       <= S_REQ;
              bus.bus_req <= 1'b1;
              src_q       <= src_addr;
              dst_q       <= dst_addr;
              cnt         <= len;
              fill_q      <= fill_sel;
              // Fill word is captured once; a normal copy overwrites data_q per word.
              data_q      <= fill_sel ? fill_value : 32'h0;
            end
          end
        end

        S_REQ: begin
          if (bus.bus_gnt) begin
            if (fill_q) begin
              state            <= S_WR;
              bus.bus_addr     <= dst_q;
              bus.bus_mem_w    <= 1'b1;
              bus.bus_data_out <= data_q;
            end else begin
              state        <= S_RD;
              bus.bus_addr <= src_q;
            end
          end
        end

        // Synchronous RAM latches the address at the end of RD; data is
        // valid during RDW, so the address is simply held.
        S_RD: state <= S_RDW;

        S_RDW: begin
          state            <= S_WR;
          data_q           <= bus.bus_data_in;
          bus.bus_addr     <= dst_q;
          bus.bus_mem_w    <= 1'b1;
          bus.bus_data_out <= bus.bus_data_in;
        end

        S_WR: begin
          src_q <= src_nx;
          dst_q <= dst_nx;
          cnt   <= cnt_nx;
          if (cnt_nx == '0) begin
            state            <= S_DONE;
            done             <= 1'b1;
            bus.bus_req      <= 1'b0;
            bus.bus_addr     <= '0;
            bus.bus_mem_w    <= 1'b0;
            bus.bus_data_out <= '0;
          end else if (bus.bus_gnt) begin
            if (fill_q) begin
              bus.bus_addr     <= dst_nx;
              bus.bus_mem_w    <= 1'b1;
              bus.bus_data_out <= data_q;
            end else begin
              state            <= S_RD;
              bus.bus_addr     <= src_nx;
              bus.bus_mem_w    <= 1'b0;
              bus.bus_data_out <= '0;
            end
          end else begin
            // Grant lost at a word boundary: keep requesting, drive nothing.
            state            <= S_REQ;
            bus.bus_addr     <= '0;
            bus.bus_mem_w    <= 1'b0;
            bus.bus_data_out <= '0;
          end
        end

        // Completion cycle; a start arriving here is dropped.
        S_DONE: state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mio_copy_engine.sv
// Bench for mio_copy_engine: directed vectors; expected bus writes are
// queued by the stimulus and popped by an independent write monitor.
module tb_mio_copy_engine;
  localparam int LEN_W = 12;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [31:0]      src_addr = '0, dst_addr = '0, fill_value = '0;
  logic [LEN_W-1:0] len = '0;
  logic             gnt = 1'b0;
  logic             busy, done, err;
  logic [LEN_W-1:0] words_left;
  logic [31:0]      rd_data = '0;

  mio_copy_engine_if bif();

  assign bif.bus_gnt     = gnt;
  assign bif.bus_data_in = rd_data;

  mio_copy_engine #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .fill_value(fill_value), .bus(bif),
    .busy(busy), .done(done), .err(err), .words_left(words_left)
  );

  always #5 clk = ~clk;

  // Synchronous memory model: word at byte address A reads as A>>2.
  always @(posedge clk) rd_data <= {2'b00, bif.bus_addr[31:2]};

  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  wr_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Write monitor
  always @(negedge clk) begin
    if (rst_n && bif.bus_mem_w) begin
      wr_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, none expected",
                 bif.bus_addr, bif.bus_data_out);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (bif.bus_addr !== e.a || bif.bus_data_out !== e.d) begin
          errors++;
          $display("FAIL write: got addr 0x%08h data 0x%08h expected addr 0x%08h data 0x%08h",
                   bif.bus_addr, bif.bus_data_out, e.a, e.d);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a; e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic do_start(input logic [31:0] s, input logic [31:0] d, input int n);
    src_addr = s; dst_addr = d; len = LEN_W'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Ticks until done; returns cycles taken, -1 on timeout (counted as failure).
  task automatic wait_done(input int max, output int cyc);
    cyc = -1;
    for (int i = 1; i <= max; i++) begin
      tick();
      if (done) begin
        cyc = i;
        break;
      end
    end
    if (cyc < 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int cyc;
    int w0;

    // Reset state
    #12;
    chk("rst_req",   {31'd0, bif.bus_req},   32'd0);
    chk("rst_addr",  bif.bus_addr,           32'd0);
    chk("rst_memw",  {31'd0, bif.bus_mem_w}, 32'd0);
    chk("rst_flags", {29'd0, busy, done, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // RAM -> VRAM, continuous grant
    gnt = 1'b1;
    push(32'hC000_0010, 32'h40);
    push(32'hC000_0011, 32'h41);
    push(32'hC000_0012, 32'h42);
    do_start(32'h0000_0100, 32'hC000_0010, 3);
    chk("t1_req",    {31'd0, bif.bus_req}, 32'd1);
    chk("t1_busy",   {31'd0, busy},        32'd1);
    chk("t1_wleft",  32'(words_left),      32'd3);
    chk("t1_reqaddr", bif.bus_addr,        32'd0);
    tick();
    chk("t1_rd_addr", bif.bus_addr,           32'h0000_0100);
    chk("t1_rd_memw", {31'd0, bif.bus_mem_w}, 32'd0);
    wait_done(20, cyc);
    chk("t1_done_cyc", 32'(cyc),             32'd9);
    chk("t1_wleft0",   32'(words_left),      32'd0);
    chk("t1_busy0",    {31'd0, busy},        32'd0);
    chk("t1_req0",     {31'd0, bif.bus_req}, 32'd0);
    tick();
    chk("t1_done_pulse", {31'd0, done},      32'd0);

    // len == 0
    do_start(32'h0000_0100, 32'h0000_0200, 0);
    chk("t2_done", {31'd0, done},        32'd1);
    chk("t2_req",  {31'd0, bif.bus_req}, 32'd0);
    chk("t2_busy", {31'd0, busy},        32'd0);
    tick();
    chk("t2_done_pulse", {31'd0, done},  32'd0);
    chk("t2_req_after",  {31'd0, bif.bus_req}, 32'd0);

    // Unaligned source
    do_start(32'h0000_0102, 32'hC000_0000, 1);
    chk("t3_err",  {31'd0, err},         32'd1);
    chk("t3_req",  {31'd0, bif.bus_req}, 32'd0);
    chk("t3_busy", {31'd0, busy},        32'd0);
    tick();
    chk("t3_err_pulse", {31'd0, err},    32'd0);
    chk("t3_idle_req",  {31'd0, bif.bus_req}, 32'd0);

    // Grant toggling, RAM -> RAM
    w0 = wr_seen;
    push(32'h0000_0300, 32'h80);
    push(32'h0000_0304, 32'h81);
    push(32'h0000_0308, 32'h82);
    push(32'h0000_030C, 32'h83);
    do_start(32'h0000_0200, 32'h0000_0300, 4);
    cyc = 0;
    while (!(bif.bus_mem_w && words_left == LEN_W'(3)) && cyc < 30) begin
      tick();
      cyc++;
    end
    chk("t4_found_wr2", {31'd0, bif.bus_mem_w}, 32'd1);
    gnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_hold_req",  {31'd0, bif.bus_req},   32'd1);
      chk("t4_hold_memw", {31'd0, bif.bus_mem_w}, 32'd0);
    end
    chk("t4_hold_wleft", 32'(words_left), 32'd2);
    gnt = 1'b1;
    wait_done(30, cyc);
    chk("t4_writes", 32'(wr_seen - w0), 32'd4);
    chk("t4_q_empty", 32'(exp_q.size()), 32'd0);
    tick();

    // Reset during RDW of word 2
    w0 = wr_seen;
    push(32'h0000_0500, 32'h100);
    do_start(32'h0000_0400, 32'h0000_0500, 5);
    cyc = 0;
    while (!bif.bus_mem_w && cyc < 30) begin
      tick();
      cyc++;
    end
    tick();  // RD of word 2
    tick();  // RDW of word 2
    chk("t5_rdw_addr", bif.bus_addr, 32'h0000_0404);
    rst_n = 1'b0;
    #1;
    chk("t5_async_req",  {31'd0, bif.bus_req},   32'd0);
    chk("t5_async_addr", bif.bus_addr,           32'd0);
    chk("t5_async_memw", {31'd0, bif.bus_mem_w}, 32'd0);
    chk("t5_async_flags", {29'd0, busy, done, err}, 32'd0);
    chk("t5_async_wleft", 32'(words_left),       32'd0);
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("t5_writes", 32'(wr_seen - w0), 32'd1);
    chk("t5_idle_req", {31'd0, bif.bus_req}, 32'd0);

`ifdef MIO_COPY_FILL_EN
    // Fill mode
    w0 = wr_seen;
    fill_value = 32'hDEAD_BEEF;
    push(32'h0000_0200, 32'hDEAD_BEEF);
    push(32'h0000_0204, 32'hDEAD_BEEF);
    do_start(32'hF000_0000, 32'h0000_0200, 2);
    tick();
    chk("t6_wr1_addr", bif.bus_addr, 32'h0000_0200);
    tick();
    chk("t6_wr2_addr", bif.bus_addr, 32'h0000_0204);
    tick();
    chk("t6_done", {31'd0, done}, 32'd1);
    chk("t6_writes", 32'(wr_seen - w0), 32'd2);
`endif

    chk("final_q_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
